// File: rtl/serial_bit_tx_pkg.sv
// Shared types and defaults for the serial bit transmitter.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_e;

  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/serial_bit_tx.sv
// Parallel-to-serial transmitter: sends In_Word[In_Len:0] MSB-first, one bit per
// clock, with an optional idle gap after each word.
//
// state | meaning
// IDLE  | ready for a word, line parked at IDLE_LVL
// SHIFT | payload bits on Out_Data, Done on bit 0
// GAP   | GAP_CYCLES idle cycles before accepting again
module serial_bit_tx
  import tx_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter logic IDLE_LVL   = 1'b0,
  parameter int   GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic [WIDTH-1:0]         In_Word,
  input  logic [$clog2(WIDTH)-1:0] In_Len,
  output logic                     Out_Data,
  output logic                     Out_Valid,
  output logic                     Done
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  tx_state_e      state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]  cnt_q;
  logic [GW-1:0]  gap_q;
  logic           ready_q;
  logic           valid_q;
  logic           data_q;
  logic           done_q;

  // Left-align the word so the shift register always emits from its MSB;
  // bits above In_Len fall off the top and are never sent.
  logic [WIDTH-1:0] sr_load_d;
  assign sr_load_d = In_Word << (CW'(WIDTH - 1) - In_Len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= IDLE_LVL;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          data_q  <= IDLE_LVL;
          if (In_Valid && ready_q) begin
            state_q <= SHIFT;
            ready_q <= 1'b0;
            valid_q <= 1'b1;
            data_q  <= sr_load_d[WIDTH-1];
            done_q  <= (In_Len == '0);
            sr_q    <= sr_load_d << 1;
            cnt_q   <= In_Len;
          end
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= IDLE_LVL;
            sr_q    <= '0;
            if (GAP_CYCLES == 0) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
            end else begin
              state_q <= GAP;
              gap_q   <= GAP_LOAD;
            end
          end else begin
            cnt_q  <= cnt_q - CW'(1);
            data_q <= sr_q[WIDTH-1];
            done_q <= (cnt_q == CW'(1));
            sr_q   <= sr_q << 1;
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign In_Ready  = ready_q;
  assign Out_Valid = valid_q;
  assign Out_Data  = data_q;
  assign Done      = done_q;

endmodule

// File: doc/serial_bit_tx.md
SERIAL_BIT_TX -- requirements
Module: serial_bit_tx

Interface
REQ-001 Parameter WIDTH, default 16, shift-register width in bits.
REQ-002 Parameter IDLE_LVL, default 1'b0, level driven on Out_Data when no bit is being sent.
REQ-003 Parameter GAP_CYCLES, default 1, idle cycles inserted after each word (0 allowed).
REQ-004 clk  input  1  single system clock; all flops rising-edge.
REQ-005 rst  input  1  asynchronous reset, active-low.
REQ-006 In_Valid  input  1  word offered on In_Word/In_Len.
REQ-007 In_Ready  output  1  block can accept a word this cycle.
REQ-008 In_Word  input  WIDTH  parallel word, sent MSB-first from bit In_Len down to bit 0.
REQ-009 In_Len  input  $clog2(WIDTH)  number of bits to send minus one (0 = 1 bit, WIDTH-1 = full word).
REQ-010 Out_Data  output  1  serial bit stream, one bit per clock, for driving a 1-bit Mealy detector input.
REQ-011 Out_Valid  output  1  Out_Data carries a payload bit this cycle.
REQ-012 Done  output  1  one-cycle pulse coincident with the last payload bit of a word.

Function
REQ-013 States SHALL be IDLE, SHIFT and GAP; all outputs SHALL be registered.
REQ-014 In IDLE the block SHALL drive In_Ready=1, Out_Valid=0, Done=0 and Out_Data=IDLE_LVL.
REQ-015 A transfer SHALL be accepted at a rising edge where In_Valid=1 and In_Ready=1; In_Word and In_Len SHALL be captured at that edge.
REQ-016 The first payload bit (In_Word[In_Len]) SHALL appear on Out_Data with Out_Valid=1 in the cycle immediately after acceptance (latency 1).
REQ-017 Each payload bit SHALL be held for exactly one clock; bit index SHALL decrement by one per cycle down to bit 0.
REQ-018 In SHIFT, In_Ready SHALL be 0; In_Valid SHALL be ignored, and In_Word/In_Len changes SHALL NOT affect the word in flight.
REQ-019 Done SHALL be 1 only in the cycle carrying bit 0 of the word.
REQ-020 After bit 0, the state SHALL go to GAP for GAP_CYCLES cycles (Out_Data=IDLE_LVL, Out_Valid=0, In_Ready=0), then to IDLE; if GAP_CYCLES=0, it SHALL go directly to IDLE.
REQ-021 A word with In_Len=0 SHALL produce exactly one payload cycle, with Done asserted in that cycle.
REQ-022 Bits of In_Word above In_Len SHALL never be transmitted.
REQ-023 The bit counter SHALL be exactly $clog2(WIDTH) bits and SHALL NOT wrap below 0; reaching 0 in SHIFT terminates the word.
REQ-024 The minimum spacing between consecutive accepted words SHALL be In_Len+1+GAP_CYCLES+1 cycles.

Reset
REQ-025 When rst=0, asynchronously and regardless of clock, the block SHALL force state=IDLE, In_Ready=0, Out_Valid=0, Done=0 and Out_Data=IDLE_LVL; the shift register and counter SHALL be cleared.
REQ-026 In_Ready SHALL rise in the first cycle after rst deasserts.
REQ-027 Reset asserted mid-word SHALL abort the word without a Done pulse; no remnant bits SHALL be sent after release.

Structure
REQ-028 Package tx_pkg SHALL hold the state enum (IDLE, SHIFT, GAP) and the default WIDTH constant.
REQ-029 The block SHALL be one module with no sub-modules: an FSM, a WIDTH-bit shift register, a bit counter and a gap counter.

Verification
REQ-030 Test: In_Word=16'h02AE, In_Len=10 accepted -> Out_Data sequence 0,1,0,1,0,1,0,1,1,1,0 on 11 consecutive Out_Valid cycles; Done is asserted only on the final 0.
REQ-031 Test: In_Word=16'h0001, In_Len=0 -> one Out_Valid cycle with Out_Data=1 and Done=1; after GAP_CYCLES=1, In_Ready returns to 1.
REQ-032 Test: In_Valid is held at 1 with In_Word changing every cycle during SHIFT -> the transmitted bits match the word captured at acceptance; the second word is accepted only on the first IDLE cycle.
REQ-033 Test: rst is pulled low asynchronously (between edges) during bit 3 of a 16-bit word -> outputs are immediately IDLE_LVL/0, there is no Done pulse, and In_Ready=1 one cycle after release.
REQ-034 Test: In_Word=16'hFFFF, In_Len=15, GAP_CYCLES=0 -> 16 ones with Out_Valid=1, Done on the 16th, then IDLE on the next cycle with Out_Data=IDLE_LVL.
REQ-035 Test: the output stream is fed into the team's Mealy detector -> the detector output matches the detector's golden sequence for the same input bits.
